// File: rtl/spi_ctrl_pkg.sv
// Shared constants and types for the SPI register controller.
package spi_ctrl_pkg;

    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h05;

    // Bit positions inside the sticky err vector.
    localparam int unsigned ERR_OPCODE = 0;
    localparam int unsigned ERR_RANGE  = 1;
    localparam int unsigned ERR_W      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_STAT,
        ST_DISCARD
    } spi_ctrl_state_e;

endpackage

// File: rtl/spi_regfile.sv
// DEPTH x 8 single-port register bank: synchronous read, write at clock edge,
// contents cleared by the asynchronous reset.
module spi_regfile #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    // Single access per cycle: write updates storage, read updates the output register.
    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (en) begin
            if (we) begin
                mem_d[addr] = wdata;
            end else begin
                rdata_d = mem_q[addr];
            end
        end
    end

    // Storage and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
            rdata_q <= 8'h00;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command decoder and register bank shared with one local requester.
// SPI accesses are issued as registered single-cycle requests and always win
// the regfile port; the local side is granted whenever SPI is not using it.
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          frame_end,
    input  logic          rx_valid,
    input  logic [7:0]    rx_byte,
    output logic [7:0]    tx_byte,
    input  logic          loc_req,
    input  logic          loc_we,
    input  logic [AW-1:0] loc_addr,
    input  logic [7:0]    loc_wdata,
    output logic          loc_gnt,
    output logic [7:0]    loc_rdata,
    output logic [1:0]    err
);

    localparam int unsigned RW = 9;

    spi_ctrl_state_e   state_q, state_d;
    logic              is_read_q, is_read_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              spi_req_q, spi_req_d;
    logic              spi_we_q, spi_we_d;
    logic [AW-1:0]     spi_addr_q, spi_addr_d;
    logic [7:0]        spi_wdata_q, spi_wdata_d;
    logic              rd_pend_q, rd_pend_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [ERR_W-1:0]  err_q, err_d;

    logic              rf_en;
    logic              rf_we;
    logic [AW-1:0]     rf_addr;
    logic [7:0]        rf_wdata;
    logic [7:0]        rf_rdata;
    logic [AW-1:0]     addr_inc;
    logic [AW-1:0]     rx_addr;

    assign addr_inc = addr_q + AW'(1);
    assign rx_addr  = rx_byte[AW-1:0];

    // Fixed-priority arbiter: the registered SPI request owns the port when present.
    assign loc_gnt  = loc_req & ~spi_req_q & ~rst;
    assign rf_en    = spi_req_q | loc_gnt;
    assign rf_we    = spi_req_q ? spi_we_q    : loc_we;
    assign rf_addr  = spi_req_q ? spi_addr_q  : loc_addr;
    assign rf_wdata = spi_req_q ? spi_wdata_q : loc_wdata;

    spi_regfile #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .en    (rf_en),
        .we    (rf_we),
        .addr  (rf_addr),
        .wdata (rf_wdata),
        .rdata (rf_rdata)
    );

    // Frame decode, address counter, SPI request generation and error flags.
    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        spi_req_d   = 1'b0;
        spi_we_d    = 1'b0;
        spi_addr_d  = spi_addr_q;
        spi_wdata_d = spi_wdata_q;
        rd_pend_d   = spi_req_q & ~spi_we_q;
        err_d       = err_q;

        if (frame_end) begin
            // A byte coinciding with frame_end is dropped.
            state_d = ST_IDLE;
            if (state_q == ST_STAT) begin
                err_d = '0;
            end
        end else if (frame_start) begin
            state_d = ST_OPCODE;
        end else if (rx_valid) begin
            unique case (state_q)
                ST_OPCODE: begin
                    unique case (rx_byte)
                        OP_WRITE: begin
                            is_read_d = 1'b0;
                            state_d   = ST_ADDR;
                        end
                        OP_READ: begin
                            is_read_d = 1'b1;
                            state_d   = ST_ADDR;
                        end
                        OP_STATUS: begin
                            state_d = ST_STAT;
                        end
                        default: begin
                            err_d[ERR_OPCODE] = 1'b1;
                            state_d           = ST_DISCARD;
                        end
                    endcase
                end
                ST_ADDR: begin
                    addr_d = rx_addr;
                    if (RW'(rx_byte) >= RW'(DEPTH)) begin
                        err_d[ERR_RANGE] = 1'b1;
                    end
                    if (is_read_q) begin
                        // Prefetch the first read byte right away.
                        spi_req_d  = 1'b1;
                        spi_addr_d = rx_addr;
                        state_d    = ST_RDATA;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    spi_req_d   = 1'b1;
                    spi_we_d    = 1'b1;
                    spi_addr_d  = addr_q;
                    spi_wdata_d = rx_byte;
                    addr_d      = addr_inc;
                end
                ST_RDATA: begin
                    spi_req_d  = 1'b1;
                    spi_addr_d = addr_inc;
                    addr_d     = addr_inc;
                end
                default: begin
                end
            endcase
        end
    end

    // Response byte: status in STAT, prefetched data in RDATA, zero otherwise.
    always_comb begin
        tx_byte_d = 8'h00;
        unique case (state_q)
            ST_STAT:  tx_byte_d = {6'b0, err_q};
            ST_RDATA: tx_byte_d = rd_pend_q ? rf_rdata : tx_byte_q;
            default:  tx_byte_d = 8'h00;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            is_read_q   <= 1'b0;
            addr_q      <= '0;
            spi_req_q   <= 1'b0;
            spi_we_q    <= 1'b0;
            spi_addr_q  <= '0;
            spi_wdata_q <= 8'h00;
            rd_pend_q   <= 1'b0;
            tx_byte_q   <= 8'h00;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            spi_req_q   <= spi_req_d;
            spi_we_q    <= spi_we_d;
            spi_addr_q  <= spi_addr_d;
            spi_wdata_q <= spi_wdata_d;
            rd_pend_q   <= rd_pend_d;
            tx_byte_q   <= tx_byte_d;
            err_q       <= err_d;
        end
    end

    assign tx_byte   = tx_byte_q;
    assign loc_rdata = rf_rdata;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl (DEPTH = 16).
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       frame_end;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       loc_req;
    logic       loc_we;
    logic [3:0] loc_addr;
    logic [7:0] loc_wdata;
    logic       loc_gnt;
    logic [7:0] loc_rdata;
    logic [1:0] err;

    int n_checks = 0;
    int n_fail   = 0;

    spi_reg_ctrl #(.DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .tx_byte     (tx_byte),
        .loc_req     (loc_req),
        .loc_we      (loc_we),
        .loc_addr    (loc_addr),
        .loc_wdata   (loc_wdata),
        .loc_gnt     (loc_gnt),
        .loc_rdata   (loc_rdata),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts cycles with nonzero tx_byte over a gap.
    task automatic gap_watch(input int n, inout int nz);
        repeat (n) begin
            @(negedge clk);
            if (tx_byte !== 8'h00) nz++;
        end
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_n(4);
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
    endtask

    // Local access with bounded wait for grant; rd is the data seen the cycle after grant.
    task automatic loc_access(input logic we, input logic [3:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output logic ok);
        ok        = 1'b0;
        loc_req   = 1'b1;
        loc_we    = we;
        loc_addr  = a;
        loc_wdata = d;
        for (int i = 0; i < 4 && !ok; i++) begin
            #1;
            if (loc_gnt) ok = 1'b1;
            @(negedge clk);
        end
        loc_req = 1'b0;
        loc_we  = 1'b0;
        rd      = loc_rdata;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        logic ok;
        n_checks++;
        if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx actual=%h required=00", tx_byte); end
        n_checks++;
        if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err actual=%b required=00", err); end
        n_checks++;
        if (loc_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt actual=%b required=0", loc_gnt); end
        n_checks++;
        if (loc_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata actual=%h required=00", loc_rdata); end
        @(negedge clk);
        rst = 1'b0;
        wait_n(2);
        loc_access(1'b0, 4'd7, 8'h00, rd, ok);
        n_checks++;
        if (ok !== 1'b1 || rd !== 8'h00) begin n_fail++; $display("FAIL reset_reg7 actual=%h gnt=%b required=00", rd, ok); end
    endtask

    task automatic test_write();
        int nz = 0;
        logic [7:0] rd;
        logic ok;
        start_frame();
        pulse_rx(8'h02); gap_watch(15, nz);
        pulse_rx(8'h03); gap_watch(15, nz);
        pulse_rx(8'hAA); gap_watch(15, nz);
        pulse_rx(8'h55); gap_watch(15, nz);
        end_frame();     gap_watch(3, nz);
        n_checks++;
        if (nz !== 0) begin n_fail++; $display("FAIL write_tx_zero actual=%0d nonzero cycles required=0", nz); end
        loc_access(1'b0, 4'd3, 8'h00, rd, ok);
        n_checks++;
        if (ok !== 1'b1 || rd !== 8'hAA) begin n_fail++; $display("FAIL write_reg3 actual=%h required=aa", rd); end
        loc_access(1'b0, 4'd4, 8'h00, rd, ok);
        n_checks++;
        if (ok !== 1'b1 || rd !== 8'h55) begin n_fail++; $display("FAIL write_reg4 actual=%h required=55", rd); end
    endtask

    task automatic test_read_wrap();
        logic [7:0] rd;
        logic ok;
        loc_access(1'b1, 4'd15, 8'h11, rd, ok);
        loc_access(1'b1, 4'd0,  8'h22, rd, ok);
        start_frame();
        pulse_rx(8'h03); wait_n(15);
        pulse_rx(8'h0F); wait_n(2);
        n_checks++;
        if (tx_byte !== 8'h11) begin n_fail++; $display("FAIL read_first actual=%h required=11", tx_byte); end
        wait_n(13);
        pulse_rx(8'hFF); wait_n(2);
        n_checks++;
        if (tx_byte !== 8'h22) begin n_fail++; $display("FAIL read_wrap actual=%h required=22", tx_byte); end
        wait_n(13);
        pulse_rx(8'hFF); wait_n(2);
        n_checks++;
        if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL read_reg1 actual=%h required=00", tx_byte); end
        end_frame(); wait_n(2);
        n_checks++;
        if (tx_byte !== 8'h00 || err !== 2'b00) begin n_fail++; $display("FAIL read_idle actual tx=%h err=%b required 00/00", tx_byte, err); end
    endtask

    task automatic test_errors();
        logic [7:0] rd;
        logic ok;
        start_frame();
        pulse_rx(8'h7E); wait_n(15);
        pulse_rx(8'h02); wait_n(15);
        pulse_rx(8'h03); wait_n(15);
        pulse_rx(8'h44); wait_n(15);
        end_frame(); wait_n(2);
        n_checks++;
        if (err !== 2'b01) begin n_fail++; $display("FAIL err_opcode actual=%b required=01", err); end
        loc_access(1'b0, 4'd3, 8'h00, rd, ok);
        n_checks++;
        if (rd !== 8'hAA) begin n_fail++; $display("FAIL discard_reg3 actual=%h required=aa", rd); end
        loc_access(1'b0, 4'd2, 8'h00, rd, ok);
        n_checks++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL discard_reg2 actual=%h required=00", rd); end

        start_frame();
        pulse_rx(8'h02); wait_n(15);
        pulse_rx(8'h20); wait_n(15);
        pulse_rx(8'h5A); wait_n(15);
        end_frame(); wait_n(2);
        n_checks++;
        if (err !== 2'b11) begin n_fail++; $display("FAIL err_range actual=%b required=11", err); end
        loc_access(1'b0, 4'd0, 8'h00, rd, ok);
        n_checks++;
        if (rd !== 8'h5A) begin n_fail++; $display("FAIL range_reg0 actual=%h required=5a", rd); end

        start_frame();
        pulse_rx(8'h05); wait_n(3);
        n_checks++;
        if (tx_byte !== 8'h03) begin n_fail++; $display("FAIL status_tx actual=%h required=03", tx_byte); end
        wait_n(12);
        end_frame(); wait_n(2);
        n_checks++;
        if (err !== 2'b00) begin n_fail++; $display("FAIL status_clear actual=%b required=00", err); end
        n_checks++;
        if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL status_tx_idle actual=%h required=00", tx_byte); end
    endtask

    task automatic test_contention();
        logic [7:0] rd;
        logic ok;
        start_frame();
        pulse_rx(8'h02); wait_n(15);
        pulse_rx(8'h05); wait_n(15);
        pulse_rx(8'h77);
        // SPI write to reg[5] executes in this cycle.
        loc_req   = 1'b1;
        loc_we    = 1'b1;
        loc_addr  = 4'd5;
        loc_wdata = 8'h99;
        #1;
        n_checks++;
        if (loc_gnt !== 1'b0) begin n_fail++; $display("FAIL contention_blocked actual=%b required=0", loc_gnt); end
        @(negedge clk); #1;
        n_checks++;
        if (loc_gnt !== 1'b1) begin n_fail++; $display("FAIL contention_next actual=%b required=1", loc_gnt); end
        @(negedge clk);
        loc_req = 1'b0;
        loc_we  = 1'b0;
        wait_n(10);
        end_frame(); wait_n(2);
        loc_access(1'b0, 4'd5, 8'h00, rd, ok);
        n_checks++;
        if (rd !== 8'h99) begin n_fail++; $display("FAIL contention_reg5 actual=%h required=99", rd); end
    endtask

    task automatic test_abort_write();
        logic [7:0] rd;
        logic ok;
        start_frame();
        pulse_rx(8'h02); wait_n(15);
        pulse_rx(8'h08); wait_n(15);
        pulse_rx(8'h33); wait_n(15);
        frame_end = 1'b1;
        rx_valid  = 1'b1;
        rx_byte   = 8'hEE;
        @(negedge clk);
        frame_end = 1'b0;
        rx_valid  = 1'b0;
        wait_n(4);
        // No frame_start: these must be ignored if the FSM is in IDLE.
        pulse_rx(8'h02); wait_n(15);
        pulse_rx(8'h09); wait_n(15);
        pulse_rx(8'hEE); wait_n(15);
        loc_access(1'b0, 4'd8, 8'h00, rd, ok);
        n_checks++;
        if (rd !== 8'h33) begin n_fail++; $display("FAIL abort_reg8 actual=%h required=33", rd); end
        loc_access(1'b0, 4'd9, 8'h00, rd, ok);
        n_checks++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL abort_reg9 actual=%h required=00", rd); end
        n_checks++;
        if (err !== 2'b00) begin n_fail++; $display("FAIL abort_err actual=%b required=00", err); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rd;
        logic ok;
        start_frame();
        pulse_rx(8'h03); wait_n(15);
        pulse_rx(8'h1F); wait_n(2);
        n_checks++;
        if (tx_byte !== 8'h11 || err !== 2'b10) begin n_fail++; $display("FAIL prereset_read actual tx=%h err=%b required 11/10", tx_byte, err); end
        wait_n(3);
        rst = 1'b1;
        #1;
        n_checks++;
        if (tx_byte !== 8'h00 || err !== 2'b00 || loc_gnt !== 1'b0 || loc_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_midread actual tx=%h err=%b gnt=%b rdata=%h required 00/00/0/00",
                     tx_byte, err, loc_gnt, loc_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        pulse_rx(8'hFF); wait_n(3);
        n_checks++;
        if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL postreset_tx actual=%h required=00", tx_byte); end
        loc_access(1'b0, 4'd15, 8'h00, rd, ok);
        n_checks++;
        if (ok !== 1'b1 || rd !== 8'h00) begin n_fail++; $display("FAIL postreset_reg15 actual=%h required=00", rd); end
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        rx_valid    = 1'b0;
        rx_byte     = 8'h00;
        loc_req     = 1'b0;
        loc_we      = 1'b0;
        loc_addr    = 4'd0;
        loc_wdata   = 8'h00;
        wait_n(3);
        test_reset();
        test_write();
        test_read_wrap();
        test_errors();
        test_contention();
        test_abort_write();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command controller behind the byte-level SPI slave datapath. It decodes the incoming SPI byte stream into register read and write transactions and supplies the response bytes the slave shifts out on MISO. It also owns a single-port register bank, which it shares between the SPI host and one local (on-FPGA) requester through a fixed-priority arbiter.

## Interface
Parameters:
- `DEPTH`, default 16: number of 8-bit registers. Must be a power of 2, at most 256.
- `AW`, default `$clog2(DEPTH)`: register address width.

Ports:
- `clk`, input, 1: system clock, the same fast clock as the SPI slave.
- `rst`, input, 1: asynchronous, active-high reset.
- `frame_start`, input, 1: one-cycle pulse when SSEL falls (synchronized).
- `frame_end`, input, 1: one-cycle pulse when SSEL rises (synchronized).
- `rx_valid`, input, 1: one-cycle pulse when a full byte has been received.
- `rx_byte`, input, 8: received byte. Valid while `rx_valid` is high.
- `tx_byte`, output, 8: next byte for the slave to shift out. The slave samples it at the next byte boundary.
- `loc_req`, input, 1: local access request. Held high until granted.
- `loc_we`, input, 1: local write enable.
- `loc_addr`, input, AW: local address.
- `loc_wdata`, input, 8: local write data.
- `loc_gnt`, output, 1: one-cycle grant. The access executes in this cycle.
- `loc_rdata`, output, 8: local read data. Valid in the cycle after `loc_gnt`.
- `err`, output, 2: sticky error flags, {range, opcode}.

## Operation
- Frame protocol:
  - Byte 0 is the opcode: 0x02 is WRITE, 0x03 is READ, 0x05 is STATUS.
  - Byte 1 is the address (WRITE and READ only).
  - Every following byte is a data byte.
  - The address auto-increments per data byte and wraps modulo DEPTH.
- FSM states: IDLE, OPCODE, ADDR, WDATA, RDATA, STAT, DISCARD.
- Transitions:
  - `frame_start` goes to OPCODE from any state.
  - `frame_end` goes to IDLE from any state. It has priority over `rx_valid` in the same cycle, so that byte is dropped.
  - In OPCODE, `rx_valid` selects the next state:
    - 0x02 or 0x03 goes to ADDR.
    - 0x05 goes to STAT.
    - Any other value goes to DISCARD and sets `err[0]`.
  - In ADDR, `rx_valid` latches the address `rx_byte[AW-1:0]`, then goes to WDATA or RDATA.
    - If `rx_byte >= DEPTH`, set `err[1]`. The masked address is still used.
  - In WDATA, each `rx_valid` writes `rx_byte` to the current address, then increments the address.
  - In RDATA:
    - On entry, prefetch the register at the current address.
    - Each `rx_valid` increments the address and prefetches again.
    - `tx_byte` takes the prefetched data.
  - In STAT, `tx_byte = {6'b0, err}`. `err` clears at the `frame_end` that closes a STATUS frame.
  - DISCARD ignores all bytes until `frame_end`.
- `tx_byte` is 0x00 in IDLE, OPCODE, ADDR-before-READ, WDATA and DISCARD.
- Rx bytes arriving in IDLE (no `frame_start` seen) are ignored.
- Arbitration:
  - The SPI side raises an internal single-cycle request on each write or prefetch.
  - SPI has fixed priority over the local requester.
  - `loc_gnt = loc_req & ~spi_req`.
  - A local request that collides with an SPI request is granted in the next free cycle. SPI accesses occur at most once per byte (16 or more clk cycles apart), so a local request waits at most 1 cycle.
- A write to the same address in the same cycle from both sides cannot happen (the SPI side wins the port).

## Timing
- Reset values: FSM in IDLE, address 0, `tx_byte` = 0x00, `loc_gnt` = 0, `loc_rdata` = 0x00, `err` = 0. Register bank contents are cleared to 0x00.
- The regfile write commits at the clock edge ending the access cycle.
- The regfile read is synchronous: data appears 1 cycle after the access.
- `rx_valid` to register write: the write is performed 1 cycle after `rx_valid`.
- `rx_valid` to updated `tx_byte` in RDATA: 3 cycles (1 cycle request, 1 cycle read, 1 cycle register), worst case with no contention.
  - This must be well below 2 SCK half-periods. The slave's SCK sync requires SCK no faster than clk/8.
- The first READ data byte is valid 3 cycles after the address byte's `rx_valid`.
- Reset asserted mid-frame aborts the frame immediately. The first byte after reset release is treated as garbage until `frame_start`.

## Structure
- Package `spi_ctrl_pkg`:
  - opcode constants `OP_WRITE`, `OP_READ`, `OP_STATUS`
  - state enum `spi_ctrl_state_e`
  - error bit indices.
- Sub-module `spi_regfile`: DEPTH x 8, single port, synchronous read, async reset clear. It is instantiated once.
- The top level holds the FSM, the address counter, the arbiter mux and the `tx_byte` register.

## Test plan
- WRITE frame: opcode 0x02, address 0x03, data 0xAA 0x55, then `frame_end`.
  - Required: reg[3] = 0xAA, reg[4] = 0x55.
  - Required: `tx_byte` stays 0x00 throughout.
- READ wrap: preload reg[15] = 0x11 and reg[0] = 0x22, then send opcode 0x03, address 0x0F, two dummy bytes.
  - Required: `tx_byte` = 0x11 within 3 cycles of the address byte, then 0x22 after the next `rx_valid`.
  - Required: address wraps to 0.
- Errors:
  - Opcode 0x7E then 3 bytes: required `err` = 2'b01, no register changed.
  - Then a WRITE to address 0x20: required `err` = 2'b11 and reg[0] written.
  - Then a STATUS frame: required `tx_byte` = 0x03, and `err` = 0 after its `frame_end`.
- Contention: hold `loc_req` (write 0x99 to reg[5]) asserted in the same cycle as an SPI write prefetch.
  - Required: `loc_gnt` deasserted that cycle and pulses the next cycle.
  - Required: the SPI write lands first; reg[5] = 0x99 afterwards.
- Abort:
  - `frame_end` coincident with `rx_valid` in WDATA: required no write, FSM in IDLE.
  - `rst` pulsed mid-READ: required all outputs at reset values in the same cycle.
